// File: rtl/key_debounce_array_if.sv
// Button bundle between the raw pins / debounced strobes and the
// key_debounce_array front end.
interface key_debounce_array_if #(
    parameter int CH = 5
);
    logic [CH-1:0] buttom_in;
    logic [CH-1:0] level;
    logic [CH-1:0] sign_pos;
    logic [CH-1:0] sign_neg;
    logic [CH-1:0] sign_long;
    logic [CH-1:0] sign_rep;
    logic          tick;

    modport master (
        output buttom_in,
        input  level, sign_pos, sign_neg, sign_long, sign_rep, tick
    );

    modport slave (
        input  buttom_in,
        output level, sign_pos, sign_neg, sign_long, sign_rep, tick
    );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel button front end: 2-flop sync, tick-sampled debounce and a
// per-channel IDLE/PRESSED/HELD FSM producing press/release/long/repeat strobes.
module key_debounce_array #(
    parameter int CH         = 5,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SAMPLE_HZ  = 1000,
    parameter int STABLE_CNT = 4,
    parameter int HOLD_CNT   = 1000,
    parameter int REPEAT_CNT = 200,
    parameter int REPEAT_EN  = 1
) (
    input  logic                 clk,
    input  logic                 buttom_rst,
    key_debounce_array_if.slave  bus
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam int HW  = $clog2(HOLD_CNT + 1);
    localparam int RW  = $clog2(REPEAT_CNT + 1);

    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] STAB_M1  = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT);
    localparam logic [RW-1:0] REP_M1   = RW'(REPEAT_CNT - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CNT);
    localparam logic          REP_ON   = (REPEAT_EN != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    logic [CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic          tick_q, tick_d;

    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] pos_q, pos_d, neg_q, neg_d, long_q, long_d, rep_q, rep_d;
    logic [CH-1:0] rise_s, fall_s;
    logic [SW-1:0] stab_cnt_q [CH];
    logic [SW-1:0] stab_cnt_d [CH];
    logic [HW-1:0] hold_cnt_q [CH];
    logic [HW-1:0] hold_cnt_d [CH];
    logic [RW-1:0] rep_cnt_q  [CH];
    logic [RW-1:0] rep_cnt_d  [CH];
    logic [1:0]    state_q    [CH];
    logic [1:0]    state_d    [CH];

    // Synchroniser chain and free-running sample prescaler.
    always_comb begin
        sync1_d = bus.buttom_in;
        sync2_d = sync1_q;
        if (pre_cnt_q == DIV_LAST) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
        end
        // tick_q is high exactly while the counter sits at DIV-1
        tick_d = (pre_cnt_d == DIV_LAST);
    end

    // Flops for synchroniser, prescaler and tick.
    always_ff @(posedge clk or negedge buttom_rst) begin
        if (!buttom_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    // Per-channel debounce and press FSM; strobes default low every cycle.
    always_comb begin
        level_d    = level_q;
        pos_d      = '0;
        neg_d      = '0;
        long_d     = '0;
        rep_d      = '0;
        rise_s     = '0;
        fall_s     = '0;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        state_d    = state_q;
        for (int c = 0; c < CH; c++) begin
            if (tick_q) begin
                if (sync2_q[c] != level_q[c]) begin
                    if (stab_cnt_q[c] >= STAB_M1) begin
                        level_d[c]    = ~level_q[c];
                        stab_cnt_d[c] = '0;
                        rise_s[c]     = ~level_q[c];
                        fall_s[c]     = level_q[c];
                    end else begin
                        stab_cnt_d[c] = stab_cnt_q[c] + SW'(1);
                    end
                end else begin
                    stab_cnt_d[c] = '0;
                end
                // A release on the same tick as an expiry suppresses the expiry strobe
                case (state_q[c])
                    ST_IDLE: begin
                        if (rise_s[c]) begin
                            pos_d[c]      = 1'b1;
                            hold_cnt_d[c] = '0;
                            state_d[c]    = ST_PRESSED;
                        end else begin
                            state_d[c]    = ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (fall_s[c]) begin
                            neg_d[c]      = 1'b1;
                            state_d[c]    = ST_IDLE;
                        end else if (hold_cnt_q[c] >= HOLD_M1) begin
                            hold_cnt_d[c] = HOLD_MAX;
                            long_d[c]     = 1'b1;
                            rep_cnt_d[c]  = '0;
                            state_d[c]    = ST_HELD;
                        end else begin
                            hold_cnt_d[c] = hold_cnt_q[c] + HW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (fall_s[c]) begin
                            neg_d[c]      = 1'b1;
                            state_d[c]    = ST_IDLE;
                        end else if (rep_cnt_q[c] >= REP_M1) begin
                            if (REP_ON) begin
                                rep_d[c]     = 1'b1;
                                rep_cnt_d[c] = '0;
                            end else begin
                                rep_cnt_d[c] = REP_MAX;
                            end
                        end else begin
                            rep_cnt_d[c] = rep_cnt_q[c] + RW'(1);
                        end
                    end
                    default: begin
                        state_d[c]    = ST_IDLE;
                        hold_cnt_d[c] = '0;
                        rep_cnt_d[c]  = '0;
                    end
                endcase
            end else begin
                state_d[c] = state_q[c];
            end
        end
    end

    // Per-channel state and registered strobe outputs.
    always_ff @(posedge clk or negedge buttom_rst) begin
        if (!buttom_rst) begin
            level_q <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            long_q  <= '0;
            rep_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                stab_cnt_q[c] <= '0;
                hold_cnt_q[c] <= '0;
                rep_cnt_q[c]  <= '0;
                state_q[c]    <= ST_IDLE;
            end
        end else begin
            level_q <= level_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            for (int c = 0; c < CH; c++) begin
                stab_cnt_q[c] <= stab_cnt_d[c];
                hold_cnt_q[c] <= hold_cnt_d[c];
                rep_cnt_q[c]  <= rep_cnt_d[c];
                state_q[c]    <= state_d[c];
            end
        end
    end

    assign bus.level     = level_q;
    assign bus.sign_pos  = pos_q;
    assign bus.sign_neg  = neg_q;
    assign bus.sign_long = long_q;
    assign bus.sign_rep  = rep_q;
    assign bus.tick      = tick_q;
endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: two instances (auto-repeat on/off) checked every
// cycle against a press-age reference model, plus directed scenario checks.
module tb_key_debounce_array;
    localparam int CH = 5, DIV = 10, STABLE = 3, HOLD = 5, REP = 2;

    logic          clk = 1'b0;
    logic          buttom_rst = 1'b0;
    logic [CH-1:0] pins = '0;

    key_debounce_array_if #(.CH(CH)) if1 ();
    key_debounce_array_if #(.CH(CH)) if0 ();
    assign if1.buttom_in = pins;
    assign if0.buttom_in = pins;

    key_debounce_array #(.CH(CH), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(STABLE),
        .HOLD_CNT(HOLD), .REPEAT_CNT(REP), .REPEAT_EN(1)) u_dut1 (
        .clk(clk), .buttom_rst(buttom_rst), .bus(if1.slave));
    key_debounce_array #(.CH(CH), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(STABLE),
        .HOLD_CNT(HOLD), .REPEAT_CNT(REP), .REPEAT_EN(0)) u_dut0 (
        .clk(clk), .buttom_rst(buttom_rst), .bus(if0.slave));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // reference model: per channel a run of disagreeing samples and the press age in ticks
    logic [CH-1:0] m_s1, m_sync, m_lvl, m_pos, m_neg, m_long, m_rep;
    logic          m_tick, m_eval;
    int            m_edges;
    int            m_run [CH];
    int            m_age [CH];

    int cnt_pos [CH], cnt_neg [CH], cnt_long [CH], cnt_rep [CH];
    int cnt_neg0 [CH], cnt_long0 [CH], cnt_rep0 [CH];
    int ntick, first_tick, w, tk, long_tk, long0_tk, neg_tk, nrep;
    int rep_tk [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_sync = '0; m_lvl = '0; m_tick = 1'b0; m_eval = 1'b0; m_edges = 0;
        m_pos = '0; m_neg = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_age[c] = 0; end
    endtask

    task automatic model_edge();
        logic [CH-1:0] old_sync;
        old_sync = m_sync;
        m_eval   = m_tick;
        m_sync   = m_s1;
        m_s1     = pins;
        m_edges++;
        m_pos = '0; m_neg = '0; m_long = '0; m_rep = '0;
        if (m_eval) begin
            for (int c = 0; c < CH; c++) begin
                if (old_sync[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == STABLE) begin
                        m_run[c] = 0;
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) begin m_pos[c] = 1'b1; m_age[c] = 0; end
                        else m_neg[c] = 1'b1;
                        continue;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_lvl[c]) begin
                    m_age[c]++;
                    if (m_age[c] == HOLD) m_long[c] = 1'b1;
                    if (m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0) m_rep[c] = 1'b1;
                end
            end
        end
        m_tick = (m_edges % DIV == DIV - 1);
    endtask

    task automatic compare_all();
        chk("tick", {31'd0, if1.tick}, {31'd0, m_tick});
        chk("level", 32'(if1.level), 32'(m_lvl));
        chk("sign_pos", 32'(if1.sign_pos), 32'(m_pos));
        chk("sign_neg", 32'(if1.sign_neg), 32'(m_neg));
        chk("sign_long", 32'(if1.sign_long), 32'(m_long));
        chk("sign_rep", 32'(if1.sign_rep), 32'(m_rep));
        chk("tick_norep", {31'd0, if0.tick}, {31'd0, m_tick});
        chk("level_norep", 32'(if0.level), 32'(m_lvl));
        chk("pos_norep", 32'(if0.sign_pos), 32'(m_pos));
        chk("neg_norep", 32'(if0.sign_neg), 32'(m_neg));
        chk("long_norep", 32'(if0.sign_long), 32'(m_long));
        chk("rep_norep", 32'(if0.sign_rep), 32'd0);
    endtask

    task automatic clear_tallies();
        for (int c = 0; c < CH; c++) begin
            cnt_pos[c] = 0; cnt_neg[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
            cnt_neg0[c] = 0; cnt_long0[c] = 0; cnt_rep0[c] = 0;
        end
        tk = 0; long_tk = -1; long0_tk = -1; neg_tk = -1; nrep = 0;
        for (int i = 0; i < 3; i++) rep_tk[i] = -1;
    endtask

    task automatic step();
        @(posedge clk);
        if (!buttom_rst) model_clear(); else model_edge();
        #1;
        compare_all();
        for (int c = 0; c < CH; c++) begin
            cnt_pos[c]   += int'(if1.sign_pos[c]);
            cnt_neg[c]   += int'(if1.sign_neg[c]);
            cnt_long[c]  += int'(if1.sign_long[c]);
            cnt_rep[c]   += int'(if1.sign_rep[c]);
            cnt_neg0[c]  += int'(if0.sign_neg[c]);
            cnt_long0[c] += int'(if0.sign_long[c]);
            cnt_rep0[c]  += int'(if0.sign_rep[c]);
        end
        if (if1.tick) begin
            ntick++;
            if (first_tick < 0) first_tick = m_edges;
        end
        // tk counts ticks since the watched channel's level rose
        if (m_eval) tk++;
        if (if1.sign_pos[w]) tk = 0;
        if (if1.sign_long[w]) long_tk = tk;
        if (if0.sign_long[w]) long0_tk = tk;
        if (if1.sign_neg[w]) neg_tk = tk;
        if (if1.sign_rep[w] && nrep < 3) begin rep_tk[nrep] = tk; nrep++; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lat;
        bit found;
        w = 0; ntick = 0; first_tick = -1;
        model_clear();
        clear_tallies();

        // 1: reset, then free run
        run(3);
        chk("rst_level", 32'(if1.level), 32'd0);
        buttom_rst = 1'b1;
        ntick = 0; first_tick = -1;
        run(30);
        chk("t1_first_tick_edge", 32'(first_tick), 32'd9);
        chk("t1_tick_count", 32'(ntick), 32'd3);

        // 2: single press / release on channel 0
        clear_tallies();
        pins[0] = 1'b1;
        found = 0; lat = 0;
        for (int i = 1; i <= 40 && !found; i++) begin step(); if (if1.level[0]) begin found = 1; lat = i; end end
        chk("t2_rise_seen", {31'd0, found}, 32'd1);
        chk("t2_rise_lat_ok", {31'd0, (lat >= 23 && lat <= 33)}, 32'd1);
        run(5);
        chk("t2_pos_cnt", 32'(cnt_pos[0]), 32'd1);
        pins[0] = 1'b0;
        found = 0; lat = 0;
        for (int i = 1; i <= 40 && !found; i++) begin step(); if (!if1.level[0]) begin found = 1; lat = i; end end
        chk("t2_fall_seen", {31'd0, found}, 32'd1);
        chk("t2_fall_lat_ok", {31'd0, (lat >= 23 && lat <= 33)}, 32'd1);
        run(5);
        chk("t2_neg_cnt", 32'(cnt_neg[0]), 32'd1);
        chk("t2_others_quiet", 32'(cnt_pos[1] + cnt_pos[2] + cnt_pos[3] + cnt_pos[4]), 32'd0);

        // 3: short press and bounce on channel 2
        clear_tallies();
        pins[2] = 1'b1;
        run(20);
        pins[2] = 1'b0;
        run(40);
        while (m_edges % DIV != 0) step();
        for (int k = 0; k < 20; k++) begin pins[2] = (k % 2 == 0); run(5); end
        pins[2] = 1'b0;
        run(40);
        chk("t3_pos_cnt", 32'(cnt_pos[2]), 32'd0);
        chk("t3_neg_cnt", 32'(cnt_neg[2]), 32'd0);
        chk("t3_level", {31'd0, if1.level[2]}, 32'd0);

        // 4: long hold with auto-repeat (dut1) and without (dut0) on channel 1
        clear_tallies();
        w = 1;
        pins[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin step(); found = if1.sign_pos[1]; end
        chk("t4_pos_seen", {31'd0, found}, 32'd1);
        for (int i = 0; i < 200 && tk < 12; i++) step();
        chk("t4_reached_12", 32'(tk), 32'd12);
        pins[1] = 1'b0;
        run(60);
        chk("t4_long_tick", 32'(long_tk), 32'd5);
        chk("t4_long0_tick", 32'(long0_tk), 32'd5);
        chk("t4_rep_a", 32'(rep_tk[0]), 32'd7);
        chk("t4_rep_b", 32'(rep_tk[1]), 32'd9);
        chk("t4_rep_c", 32'(rep_tk[2]), 32'd11);
        chk("t4_rep0_cnt", 32'(cnt_rep0[1]), 32'd0);
        chk("t4_long_cnt", 32'(cnt_long[1]), 32'd1);
        chk("t4_neg_cnt", 32'(cnt_neg[1]), 32'd1);
        chk("t4_neg0_cnt", 32'(cnt_neg0[1]), 32'd1);

        // 5: simultaneous press on 1 and 3, release landing on the HOLD-th tick
        clear_tallies();
        w = 1;
        pins[1] = 1'b1; pins[3] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin step(); found = if1.sign_pos[1]; end
        chk("t5_pos1_seen", {31'd0, found}, 32'd1);
        chk("t5_pos3_same_cycle", {31'd0, if1.sign_pos[3]}, 32'd1);
        for (int i = 0; i < 60 && tk < 2; i++) step();
        pins[1] = 1'b0; pins[3] = 1'b0;
        run(60);
        chk("t5_neg_tick", 32'(neg_tk), 32'd5);
        chk("t5_long_cnt", 32'(cnt_long[1] + cnt_long[3] + cnt_long0[1] + cnt_long0[3]), 32'd0);
        chk("t5_neg_cnt1", 32'(cnt_neg[1]), 32'd1);
        chk("t5_neg_cnt3", 32'(cnt_neg[3]), 32'd1);

        // 6: reset mid-press on channel 4
        clear_tallies();
        w = 4;
        pins[4] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin step(); found = if1.level[4]; end
        chk("t6_level_up", {31'd0, found}, 32'd1);
        run(3);
        #2;
        buttom_rst = 1'b0;
        #1;
        model_clear();
        compare_all();
        chk("t6_async_level", 32'(if1.level), 32'd0);
        chk("t6_async_strobes", 32'(if1.sign_pos | if1.sign_neg | if1.sign_long | if1.sign_rep), 32'd0);
        run(4);
        buttom_rst = 1'b1;
        ntick = 0; first_tick = -1;
        found = 0; lat = 0;
        for (int i = 0; i < 60 && !found; i++) begin step(); found = if1.sign_pos[4]; lat = m_edges; end
        chk("t6_repos_seen", {31'd0, found}, 32'd1);
        chk("t6_repos_edge", 32'(lat), 32'd30);
        chk("t6_first_tick_edge", 32'(first_tick), 32'd9);
        run(20);
        chk("t6_no_neg_while_high", 32'(cnt_neg[4] + cnt_neg0[4]), 32'd0);
        pins[4] = 1'b0;
        run(40);
        chk("t6_neg_after_drop", 32'(cnt_neg[4]), 32'd1);

        // random pin activity against the model
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) pins[$urandom_range(0, CH - 1)] ^= 1'b1;
            step();
        end
        pins = '0;
        run(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
